id_stage_pipelined: RTL
=======================

# id_stage_pipelined

Parametrised instruction-decode stage with an integrated register file, same-cycle write-back bypass, load-use hazard detection and an internal ID/EXE pipeline register. It sits between the IF/ID register and EXE. It consumes the instruction word plus the combinational control bundle from the controller. It produces registered operands and control for EXE with a valid/ready handshake, and drives a stall signal back to IF.

## Interface
- DATA_W, 32, operand and register width
- REG_CNT, 32, number of architectural registers; power of 2, range 2..32; AW = clog2(REG_CNT)
- IMM_W, 16, immediate field width; instruction[IMM_W-1:0], sign-extended to DATA_W
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  IF/ID holds a valid instruction
- instruction  in  32  opcode [31:26], rs [25:21], rt [20:16], rd [15:11]; register fields use their low AW bits
- is_immediate, mem_r_en, mem_w_en, wb_en  in  1 each  controller decode of the current instruction
- exe_cmd  in  4  controller ALU command
- br_type  in  2  controller branch type
- wb_we  in  1  write-back enable
- wb_dest  in  AW  write-back register index
- wb_data  in  DATA_W  write-back data
- exe_ready  in  1  EXE accepts the ID/EXE register contents this cycle
- flush  in  1  kill the instruction currently in ID (taken branch)
- stall  out  1  hold PC and IF/ID this cycle
- out_valid  out  1  ID/EXE register holds a real instruction
- val1, val2, reg2  out  DATA_W each  registered rs value, ALU operand 2, rt value (store data)
- dest  out  AW  registered destination index
- exe_cmd_q  out  4  registered exe_cmd
- br_type_q  out  2  registered br_type
- mem_r_en_q, mem_w_en_q, wb_en_q  out  1 each  registered enables

## Operation
- **Register file.** REG_CNT × DATA_W. Reg 0 reads as 0 at all times. It is written on a clk edge when wb_we=1 and wb_dest≠0.
- **Read ports.** rs and rt are combinational. Bypass: if wb_we=1, wb_dest equals the source index and the index is ≠0, the port returns wb_data in the same cycle.
- **Operand 2.** val2 source = is_immediate ? sext(instruction[IMM_W-1:0]) : rt value. reg2 source = rt value always.
- **Destination.** dest source = is_immediate ? rt : rd.
- **rt usage.** uses_rt = !is_immediate | mem_w_en.
- **Load-use hazard.** hazard = in_valid & out_valid & mem_r_en_q & dest≠0 & (dest==rs | (uses_rt & dest==rt)).
- **Register load condition.** ld = exe_ready | !out_valid.
- **Register update when ld=1.**
  - If in_valid & !flush & !hazard: capture the new instruction with out_valid=1.
  - Otherwise: load a bubble. A bubble has out_valid=0, mem_r_en_q, mem_w_en_q and wb_en_q all 0, and every other field 0.
- **Register update when ld=0.** All ID/EXE outputs hold.
- **Stall.** stall = in_valid & !flush & (hazard | !ld).
- **Flush.** flush overrides both hazard and stall. The ID instruction is discarded and stall=0. A held (ld=0) register is never discarded by flush.

## Timing
- Reset: all register-file entries 0. out_valid, all *_q enables, val1, val2, reg2, dest, exe_cmd_q and br_type_q are 0. stall is combinationally 0 while out_valid=0.
- Latency: an instruction presented with stall=0 appears on the outputs 1 cycle later.
- Load-use: exactly 1 stall cycle when EXE is ready.
  - Cycle N: the load is in ID/EXE and the dependent instruction is in ID, so stall=1.
  - Edge N+1: a bubble is loaded and the hazard clears.
  - Edge N+2: the dependent instruction is captured. Its load data arrives via bypass when it is written back in that cycle.
- Backpressure: while out_valid=1 and exe_ready=0, outputs are stable and stall=1 (if in_valid). No instruction is lost or duplicated.
- Write and read of the same register in one cycle: the read returns the new data, and the register holds the new data after the edge.
- rst asserted mid-stall: the next edge clears everything and stall drops.

## Test plan
- **Reset.** Hold rst for 2 cycles → all outputs 0, stall=0. Reading any register afterwards returns 0.
- **Bypass and r0.**
  - Drive wb_we=1, wb_dest=3, wb_data=0xDEADBEEF while ID decodes rs=3 → val1=0xDEADBEEF next cycle.
  - wb_dest=0 with wb_data=0x5 → r0 still reads 0.
- **Immediate.** is_immediate=1, instruction[15:0]=0xFFFF, rt=7 → val2=0xFFFFFFFF, dest=7, reg2 = r7 contents.
- **Load-use.** Load with dest=5 followed by add with rs=5 → stall=1 for 1 cycle, one bubble (out_valid=0), then the add is captured with the bypassed load data. Repeat with the dependency on rt=5 of an immediate ALU instruction → no stall.
- **Backpressure.** exe_ready=0 for 3 cycles with out_valid=1 → outputs unchanged, stall=1 for 3 cycles. Then exe_ready=1 → the next instruction is captured on the following edge.
- **Flush.**
  - flush=1 with in_valid=1 and ld=1 → bubble loaded, stall=0.
  - flush=1 coinciding with a hazard → stall=0.
  - flush=1 with ld=0 → the held instruction persists.

Source files
------------

// File: rtl/id_stage_pipelined.sv
// Decode stage: register file with write-back bypass, load-use hazard detection and ID/EXE register.
// One-cycle latency; ID/EXE holds and stall rises while EXE is not ready, flush drops the ID instruction.
module id_stage_pipelined #(
    parameter  int DATA_W  = 32,
    parameter  int REG_CNT = 32,
    parameter  int IMM_W   = 16,
    localparam int AW      = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       instruction,
    input  logic              is_immediate,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              wb_en,
    input  logic [3:0]        exe_cmd,
    input  logic [1:0]        br_type,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              exe_ready,
    input  logic              flush,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] val1,
    output logic [DATA_W-1:0] val2,
    output logic [DATA_W-1:0] reg2,
    output logic [AW-1:0]     dest,
    output logic [3:0]        exe_cmd_q,
    output logic [1:0]        br_type_q,
    output logic              mem_r_en_q,
    output logic              mem_w_en_q,
    output logic              wb_en_q
);

    typedef struct packed {
        logic              vld;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              wb_en;
        logic [3:0]        exe_cmd;
        logic [1:0]        br_type;
        logic [AW-1:0]     dest;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] reg2;
    } idex_t;

    logic [DATA_W-1:0] rf_q [REG_CNT];
    idex_t             idex_d, idex_q;

    logic [AW-1:0]     rs_idx, rt_idx, rd_idx;
    logic [DATA_W-1:0] rs_val, rt_val, imm_ext;
    logic              uses_rt, hazard, ld, capture;
    logic              unused_opcode;

    assign rs_idx  = instruction[21 +: AW];
    assign rt_idx  = instruction[16 +: AW];
    assign rd_idx  = instruction[11 +: AW];
    assign imm_ext = DATA_W'($signed(instruction[IMM_W-1:0]));
    assign unused_opcode = ^instruction[31:26];

    // Entry 0 is never written; reads of it are forced to zero regardless.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) rf_q[i] <= '0;
        end else if (wb_we && wb_dest != '0) begin
            rf_q[wb_dest] <= wb_data;
        end
    end

    assign rs_val = (rs_idx == '0)                  ? '0      :
                    (wb_we && wb_dest == rs_idx)    ? wb_data : rf_q[rs_idx];
    assign rt_val = (rt_idx == '0)                  ? '0      :
                    (wb_we && wb_dest == rt_idx)    ? wb_data : rf_q[rt_idx];

    // Stores read rt as data even though their operand 2 is the immediate.
    assign uses_rt = !is_immediate || mem_w_en;
    assign hazard  = in_valid && idex_q.vld && idex_q.mem_r_en && idex_q.dest != '0 &&
                     (idex_q.dest == rs_idx || (uses_rt && idex_q.dest == rt_idx));
    assign ld      = exe_ready || !idex_q.vld;
    assign capture = in_valid && !flush && !hazard;
    assign stall   = in_valid && !flush && (hazard || !ld);

    always_comb begin
        idex_d = idex_q;
        if (ld) begin
            idex_d = '0;
            if (capture) begin
                idex_d.vld      = 1'b1;
                idex_d.mem_r_en = mem_r_en;
                idex_d.mem_w_en = mem_w_en;
                idex_d.wb_en    = wb_en;
                idex_d.exe_cmd  = exe_cmd;
                idex_d.br_type  = br_type;
                idex_d.dest     = is_immediate ? rt_idx : rd_idx;
                idex_d.val1     = rs_val;
                idex_d.val2     = is_immediate ? imm_ext : rt_val;
                idex_d.reg2     = rt_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) idex_q <= '0;
        else     idex_q <= idex_d;
    end

    assign out_valid  = idex_q.vld;
    assign val1       = idex_q.val1;
    assign val2       = idex_q.val2;
    assign reg2       = idex_q.reg2;
    assign dest       = idex_q.dest;
    assign exe_cmd_q  = idex_q.exe_cmd;
    assign br_type_q  = idex_q.br_type;
    assign mem_r_en_q = idex_q.mem_r_en;
    assign mem_w_en_q = idex_q.mem_w_en;
    assign wb_en_q    = idex_q.wb_en;

endmodule
